// File: rtl/mem_arbiter.sv
// Round-robin req/ack arbiter sharing one single-port memory between an
// instruction-fetch port (A, read-only) and a load/store port (B).
module mem_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_req,
  input  logic [31:0]       a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_b
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_b_q, last_b_d;
  logic                owner_b_q, owner_b_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  // B wins a tie only when A was served last; reset leaves last = B so A goes first.
  logic        grant, grant_b, out_of_range;
  logic [31:0] sel_addr;
  assign grant        = a_req | b_req;
  assign grant_b      = b_req & (~a_req | ~last_b_q);
  assign sel_addr     = grant_b ? b_addr : a_addr;
  assign out_of_range = |sel_addr[31:ADDR_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (grant) state_d = out_of_range ? S_ACK : S_ACCESS;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: every _d gets a hold default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    we_d      = we_q;
    err_d     = err_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          addr_d    = sel_addr;
          wdata_d   = b_wdata;
          we_d      = grant_b & b_we;
          owner_b_d = grant_b;
          last_b_d  = grant_b;
          err_d     = out_of_range;
          if (out_of_range) begin
            a_ack_d = ~grant_b;
            b_ack_d = grant_b;
          end else begin
            cnt_d = WAIT_INIT;
            rd_d  = ~(grant_b & b_we);
            wr_d  = grant_b & b_we;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          a_ack_d = ~owner_b_q;
          b_ack_d = owner_b_q;
          if (!we_q) begin
            if (owner_b_q) b_rdata_d = mem_rdata;
            else           a_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    owner_b   = owner_b_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_read  = rd_q;
    mem_write = wr_q;
    a_ack     = a_ack_q;
    b_ack     = b_ack_q;
    a_err     = a_ack_q & err_q;
    b_err     = b_ack_q & err_q;
    a_rdata   = a_rdata_q;
    b_rdata   = b_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait cycle and one
// with three, each driving a small level-write memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---- instance with WAIT_CYCLES = 1
  logic        a_req, a_ack, a_err, b_req, b_we, b_ack, b_err;
  logic [31:0] a_addr, b_addr, b_wdata, a_rdata, b_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write, busy, owner_b;
  logic [31:0] mem1 [512];

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_read(m_read), .mem_write(m_write),
    .mem_rdata(m_rdata), .busy(busy), .owner_b(owner_b)
  );

  assign m_rdata = mem1[m_addr[8:0]];
  always @(negedge clk) if (m_write) mem1[m_addr[8:0]] = m_wdata;

  // ---- instance with WAIT_CYCLES = 3
  logic        w3_a_req, w3_a_ack, w3_a_err, w3_b_req, w3_b_we, w3_b_ack, w3_b_err;
  logic [31:0] w3_a_addr, w3_b_addr, w3_b_wdata, w3_a_rdata, w3_b_rdata;
  logic [31:0] w3_m_addr, w3_m_wdata, w3_m_rdata;
  logic        w3_m_read, w3_m_write, w3_busy, w3_owner_b;
  logic [31:0] mem3 [512];

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .clr(clr),
    .a_req(w3_a_req), .a_addr(w3_a_addr), .a_ack(w3_a_ack), .a_rdata(w3_a_rdata),
    .a_err(w3_a_err),
    .b_req(w3_b_req), .b_we(w3_b_we), .b_addr(w3_b_addr), .b_wdata(w3_b_wdata),
    .b_ack(w3_b_ack), .b_rdata(w3_b_rdata), .b_err(w3_b_err),
    .mem_addr(w3_m_addr), .mem_wdata(w3_m_wdata), .mem_read(w3_m_read),
    .mem_write(w3_m_write), .mem_rdata(w3_m_rdata), .busy(w3_busy), .owner_b(w3_owner_b)
  );

  assign w3_m_rdata = mem3[w3_m_addr[8:0]];
  always @(negedge clk) if (w3_m_write) mem3[w3_m_addr[8:0]] = w3_m_wdata;

  // Strobe monitor: both strobes together, or address/data moving under a strobe.
  int          viol = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    if (m_read && m_write) viol++;
    if (w3_m_read && w3_m_write) viol++;
    if (prev_strobe && (m_read || m_write) && (m_addr !== prev_addr || m_wdata !== prev_wdata))
      viol++;
    prev_strobe = m_read | m_write;
    prev_addr   = m_addr;
    prev_wdata  = m_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_req = 0; a_addr = 0; b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    w3_a_req = 0; w3_a_addr = 0; w3_b_req = 0; w3_b_we = 0; w3_b_addr = 0; w3_b_wdata = 0;
    for (int i = 0; i < 512; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem1[0]  = 32'h5A;
    mem1[5]  = 32'h55;
    mem1[10] = 32'h11;
    mem1[20] = 32'h22;
    mem1[43] = 32'h2;
    mem3[95] = 32'hD;

    #12 clr = 0;
    // Reset state
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mem_read", {31'b0, m_read}, 0);
    check("rst_mem_write", {31'b0, m_write}, 0);
    check("rst_owner_b", {31'b0, owner_b}, 0);
    check("rst_acks", {30'b0, a_ack, b_ack}, 0);
    check("rst_errs", {30'b0, a_err, b_err}, 0);
    check("rst_mem_addr", m_addr, 0);
    check("rst_a_rdata", a_rdata, 0);
    step();

    // Single read, one wait cycle
    a_req = 1; a_addr = 43;
    step();
    check("rd_strobe", {31'b0, m_read}, 1);
    check("rd_addr", m_addr, 43);
    check("rd_no_early_ack", {31'b0, a_ack}, 0);
    check("rd_busy", {31'b0, busy}, 1);
    step();
    a_req = 0;
    check("rd_strobe_off", {31'b0, m_read}, 0);
    check("rd_ack", {31'b0, a_ack}, 1);
    check("rd_data", a_rdata, 32'h2);
    check("rd_err", {31'b0, a_err}, 0);
    step();
    check("rd_ack_pulse", {31'b0, a_ack}, 0);
    check("rd_idle", {31'b0, busy}, 0);

    // B write then read
    b_req = 1; b_we = 1; b_addr = 87; b_wdata = 32'hDEADBEEF;
    step();
    check("wr_strobe", {31'b0, m_write}, 1);
    check("wr_no_read", {31'b0, m_read}, 0);
    check("wr_addr", m_addr, 87);
    check("wr_data", m_wdata, 32'hDEADBEEF);
    check("wr_owner", {31'b0, owner_b}, 1);
    step();
    b_req = 0;
    check("wr_ack", {31'b0, b_ack}, 1);
    check("wr_strobe_off", {31'b0, m_write}, 0);
    check("wr_rdata_kept", b_rdata, 0);
    check("wr_err", {31'b0, b_err}, 0);
    step();
    check("wr_mem", mem1[87], 32'hDEADBEEF);
    b_req = 1; b_we = 0;
    step();
    check("rb_strobe", {31'b0, m_read}, 1);
    step();
    b_req = 0;
    check("rb_ack", {31'b0, b_ack}, 1);
    check("rb_data", b_rdata, 32'hDEADBEEF);
    step();

    // Contention: both held, last served B so order is A, B, A, B
    a_req = 1; a_addr = 10; b_req = 1; b_we = 0; b_addr = 20;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ct_owner", {31'b0, owner_b}, (i % 2 == 1) ? 1 : 0);
      check("ct_addr", m_addr, (i % 2 == 1) ? 20 : 10);
      check("ct_strobe", {31'b0, m_read}, 1);
      step();
      check("ct_acks", {30'b0, a_ack, b_ack}, (i % 2 == 1) ? 32'b01 : 32'b10);
      if (i % 2 == 1) check("ct_b_rdata", b_rdata, 32'h22);
      else            check("ct_a_rdata", a_rdata, 32'h11);
      step();
      check("ct_idle", {31'b0, busy}, 0);
    end
    a_req = 0; b_req = 0;
    step();
    check("ct_strobe_rules", viol, 0);

    // Out of range write from B
    b_req = 1; b_we = 1; b_addr = 32'h200; b_wdata = 32'hFFFFFFFF;
    step();
    b_req = 0;
    check("oor_ack", {31'b0, b_ack}, 1);
    check("oor_err", {31'b0, b_err}, 1);
    check("oor_strobes", {30'b0, m_read, m_write}, 0);
    check("oor_a_err", {31'b0, a_err}, 0);
    check("oor_rdata_kept", b_rdata, 32'h22);
    step();
    check("oor_ack_pulse", {31'b0, b_ack}, 0);
    check("oor_err_qual", {31'b0, b_err}, 0);
    check("oor_word0", mem1[0], 32'h5A);

    // Three wait cycles; request dropped during ACCESS
    w3_a_req = 1; w3_a_addr = 95;
    step();
    w3_a_req = 0;
    check("w3_strobe1", {31'b0, w3_m_read}, 1);
    check("w3_addr", w3_m_addr, 95);
    step();
    check("w3_strobe2", {31'b0, w3_m_read}, 1);
    check("w3_no_ack2", {31'b0, w3_a_ack}, 0);
    step();
    check("w3_strobe3", {31'b0, w3_m_read}, 1);
    check("w3_no_ack3", {31'b0, w3_a_ack}, 0);
    step();
    check("w3_strobe_off", {31'b0, w3_m_read}, 0);
    check("w3_ack", {31'b0, w3_a_ack}, 1);
    check("w3_data", w3_a_rdata, 32'hD);
    step();
    check("w3_idle", {31'b0, w3_busy}, 0);

    // Reset pulsed mid-ACCESS
    a_req = 1; a_addr = 5;
    step();
    check("rs_strobe_before", {31'b0, m_read}, 1);
    #2 clr = 1;
    #1;
    check("rs_strobe_drop", {31'b0, m_read}, 0);
    check("rs_busy", {31'b0, busy}, 0);
    check("rs_mem_addr", m_addr, 0);
    check("rs_rdata", {a_rdata[15:0], b_rdata[15:0]}, 0);
    check("rs_owner", {31'b0, owner_b}, 0);
    a_req = 0;
    step();
    check("rs_no_ack", {30'b0, a_ack, b_ack}, 0);
    #2 clr = 0;
    step();
    a_req = 1;
    step();
    check("rs_next_strobe", {31'b0, m_read}, 1);
    check("rs_next_addr", m_addr, 5);
    step();
    a_req = 0;
    check("rs_next_ack", {31'b0, a_ack}, 1);
    check("rs_next_data", a_rdata, 32'h55);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
